datapath_src_arb2: RTL and testbench
====================================

DATAPATH_SRC_ARB2 -- requirements
Module: datapath_src_arb2

Interface
REQ-001 SHALL have parameter DWID, default 24, bit width of one channel word.
REQ-002 SHALL have parameter CH_NUM, default 32, number of channel words per beat.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports A0_valid/A0_last  input  1 each  source 0 beat valid / end of packet.
REQ-006 SHALL have port A0_data  input  [CH_NUM-1:0][DWID-1:0]  source 0 beat.
REQ-007 SHALL have port A0_ready  output  1  source 0 beat accepted when A0_valid & A0_ready.
REQ-008 SHALL have ports A1_valid, A1_last, A1_data, A1_ready, mirroring REQ-005..007 for source 1.
REQ-009 SHALL have ports Z_valid/Z_last  output  1 each  merged beat valid / end of packet.
REQ-010 SHALL have port Z_data  output  [CH_NUM-1:0][DWID-1:0]  merged beat.
REQ-011 SHALL have port Z_src  output  1  source id of current Z beat (0 = A0, 1 = A1).
REQ-012 SHALL have port Z_ready  input  1  sink accepts when Z_valid & Z_ready.

Function
- Packet-granular 2:1 merge, round-robin, 2-entry output buffer.
REQ-013 SHALL implement arbitration FSM states IDLE, LOCK0, LOCK1.
REQ-014 SHALL in IDLE grant the sole valid source; if both valid, grant the source != rr_last; if neither, grant none.
REQ-015 SHALL in LOCKn grant only source n, regardless of the other source's valid.
REQ-016 SHALL transition IDLE->LOCKn when a non-last beat from source n is accepted.
REQ-017 SHALL transition LOCKn->IDLE when a beat with An_last=1 is accepted.
REQ-018 SHALL stay in IDLE for a single-beat packet (last on first accepted beat).
REQ-019 SHALL update rr_last to n on every accepted last beat from source n.
REQ-020 SHALL drive An_ready = granted(n) & ~buf_full; ungranted source ready = 0.
REQ-021 SHALL never let An_ready depend combinationally on Z_ready.
REQ-022 SHALL push {src, last, data} of each accepted beat into the 2-entry buffer.
REQ-023 SHALL drive Z_valid = ~buf_empty; Z_data, Z_last, Z_src from buffer head.
REQ-024 SHALL present a beat on Z exactly 1 cycle after acceptance when buffer was empty.
REQ-025 SHALL sustain one beat per cycle when Z_ready held high.
REQ-026 SHALL support simultaneous push and pop, occupancy unchanged, including when full (pop frees, push blocked that cycle because ready is computed from registered full).
REQ-027 SHALL hold Z_data/Z_last/Z_src stable while Z_valid & ~Z_ready.
REQ-028 SHALL never interleave beats of two packets on Z.

Reset
REQ-029 SHALL on rst: FSM=IDLE, rr_last=1 (so A0 wins first tie), buffer empty.
REQ-030 SHALL drive during/after reset: Z_valid=0, Z_last=0, Z_src=0, Z_data=0, A0_ready=0, A1_ready=0 while rst high.
REQ-031 SHALL discard buffered beats and any partial-packet lock on reset mid-packet; next packet arbitrated fresh.

Structure
REQ-032 SHALL place state enum typedef (IDLE/LOCK0/LOCK1) and constant BUF_DEPTH=2 in shared package datapath_pkg.
REQ-033 SHALL implement the buffer as sub-module datapath_skid2 (2-entry, push/pop, full/empty flags).

Verification
REQ-034 SHALL cover: both sources valid, 1-beat packets from reset, Z_ready=1 -> Z_src sequence 0,1,0,1, one beat/cycle.
REQ-035 SHALL cover: A0 4-beat packet, A1 valid from beat 2 -> Z_src 0,0,0,0 then 1; A1_ready=0 until A0 last accepted.
REQ-036 SHALL cover: Z_ready=0 for 5 cycles with A0 streaming -> exactly 2 beats accepted, A0_ready=0 thereafter, no beat loss or reorder on release.
REQ-037 SHALL cover: Z_ready toggling 1,0,1,0 with both sources backlogged -> Z_data stable on stalled cycles, packet order per REQ-014.
REQ-038 SHALL cover: rst asserted mid A1 3-beat packet after beat 2 -> Z_valid=0 next cycle, FSM IDLE, next tie granted to A0.
REQ-039 SHALL cover: only A1 valid, data 0x000001..0x000003 with last on 3rd -> Z_data identical order, Z_last on 3rd, latency 1 cycle.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types and constants for the two-source packet merger.
package datapath_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/datapath_skid2.sv
// Two-entry output buffer with push/pop and full/empty flags.
module datapath_skid2
    import datapath_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [W-1:0]  mem [BUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == CW'(BUF_DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/datapath_src_arb2.sv
// Packet-granular round-robin 2:1 merge feeding a two-entry buffer.
module datapath_src_arb2
    import datapath_pkg::*;
#(
    parameter int DWID   = 24,
    parameter int CH_NUM = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         A0_valid,
    input  logic                         A0_last,
    input  logic [CH_NUM-1:0][DWID-1:0]  A0_data,
    output logic                         A0_ready,
    input  logic                         A1_valid,
    input  logic                         A1_last,
    input  logic [CH_NUM-1:0][DWID-1:0]  A1_data,
    output logic                         A1_ready,
    output logic                         Z_valid,
    output logic                         Z_last,
    output logic [CH_NUM-1:0][DWID-1:0]  Z_data,
    output logic                         Z_src,
    input  logic                         Z_ready
);

    localparam int BW = CH_NUM * DWID;
    localparam int EW = BW + 2;

    arb_state_t    state;
    logic          rr_last;
    logic          gnt0;
    logic          gnt1;
    logic          buf_full;
    logic          buf_empty;
    logic          acc0;
    logic          acc1;
    logic          push;
    logic          push_last;
    logic [EW-1:0] push_ent;
    logic [EW-1:0] head_ent;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state)
            LOCK0: gnt0 = 1'b1;
            LOCK1: gnt1 = 1'b1;
            default: begin
                gnt0 = A0_valid & (~A1_valid | rr_last);
                gnt1 = A1_valid & (~A0_valid | ~rr_last);
            end
        endcase
    end

    // Ready uses only registered fullness, never Z_ready.
    assign A0_ready  = gnt0 & ~buf_full & ~rst;
    assign A1_ready  = gnt1 & ~buf_full & ~rst;
    assign acc0      = A0_valid & A0_ready;
    assign acc1      = A1_valid & A1_ready;
    assign push      = acc0 | acc1;
    assign push_last = acc1 ? A1_last : A0_last;
    assign push_ent  = acc1 ? {1'b1, A1_last, A1_data}
                            : {1'b0, A0_last, A0_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_last <= 1'b1;
        end else if (push) begin
            if (push_last) begin
                state   <= IDLE;
                rr_last <= acc1;
            end else begin
                state <= acc1 ? LOCK1 : LOCK0;
            end
        end
    end

    datapath_skid2 #(
        .W (EW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_ent),
        .pop       (Z_ready),
        .head_data (head_ent),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign Z_valid = ~buf_empty & ~rst;
    assign Z_src   = head_ent[EW-1] & ~rst;
    assign Z_last  = head_ent[EW-2] & ~rst;
    assign Z_data  = rst ? '0 : head_ent[BW-1:0];

endmodule

// File: tb/tb_datapath_src_arb2.sv
// Randomized and directed checks of the merger against a queue model.
module tb_datapath_src_arb2;

    localparam int DWID   = 24;
    localparam int CH_NUM = 2;
    localparam int BW     = DWID * CH_NUM;

    typedef struct {
        bit            last;
        logic [BW-1:0] data;
    } beat_t;

    typedef struct {
        bit            src;
        bit            last;
        logic [BW-1:0] data;
    } zbeat_t;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        A0_valid, A0_last, A0_ready;
    logic                        A1_valid, A1_last, A1_ready;
    logic [CH_NUM-1:0][DWID-1:0] A0_data, A1_data, Z_data;
    logic                        Z_valid, Z_last, Z_src, Z_ready;

    always #5 clk = ~clk;

    datapath_src_arb2 #(
        .DWID   (DWID),
        .CH_NUM (CH_NUM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .A0_valid (A0_valid),
        .A0_last  (A0_last),
        .A0_data  (A0_data),
        .A0_ready (A0_ready),
        .A1_valid (A1_valid),
        .A1_last  (A1_last),
        .A1_data  (A1_data),
        .A1_ready (A1_ready),
        .Z_valid  (Z_valid),
        .Z_last   (Z_last),
        .Z_data   (Z_data),
        .Z_src    (Z_src),
        .Z_ready  (Z_ready)
    );

    int     total = 0;
    int     bad   = 0;
    beat_t  q0[$];
    beat_t  q1[$];
    zbeat_t mfifo[$];
    zbeat_t zlog[$];
    beat_t  saved[$];
    bit     en0, en1;
    int     lock;
    int     rr;
    int     dut_acc0, dut_acc1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic add_pkt(input int s, input int len);
        beat_t      b;
        logic [63:0] r;
        for (int i = 0; i < len; i++) begin
            r      = {$urandom, $urandom};
            b.data = r[BW-1:0];
            b.last = (i == len - 1);
            if (s == 0) q0.push_back(b);
            else        q1.push_back(b);
        end
    endtask

    task automatic step(input bit zr);
        bit     v0, v1, g0, g1, r0, r1, zv;
        zbeat_t zb;
        @(negedge clk);
        v0 = en0 && q0.size() > 0;
        v1 = en1 && q1.size() > 0;
        A0_valid = v0;
        A0_last  = v0 ? q0[0].last : 1'b0;
        A0_data  = v0 ? q0[0].data : '0;
        A1_valid = v1;
        A1_last  = v1 ? q1[0].last : 1'b0;
        A1_data  = v1 ? q1[0].data : '0;
        Z_ready  = zr;
        #1;
        if (lock == 0) begin
            g0 = 1; g1 = 0;
        end else if (lock == 1) begin
            g0 = 0; g1 = 1;
        end else if (v0 && v1) begin
            g0 = (rr == 1); g1 = (rr == 0);
        end else begin
            g0 = v0; g1 = v1;
        end
        r0 = g0 && mfifo.size() < 2;
        r1 = g1 && mfifo.size() < 2;
        zv = mfifo.size() > 0;
        chk("a0_ready", A0_ready, r0);
        chk("a1_ready", A1_ready, r1);
        chk("z_valid", Z_valid, zv);
        if (zv) begin
            chk("z_src", Z_src, mfifo[0].src);
            chk("z_last", Z_last, mfifo[0].last);
            chk("z_data", Z_data, mfifo[0].data);
        end
        if (Z_valid && zr) begin
            zb.src = Z_src; zb.last = Z_last; zb.data = Z_data;
            zlog.push_back(zb);
        end
        if (A0_valid && A0_ready) dut_acc0++;
        if (A1_valid && A1_ready) dut_acc1++;
        if (zv && zr) void'(mfifo.pop_front());
        if (v0 && r0) begin
            zb.src = 0; zb.last = q0[0].last; zb.data = q0[0].data;
            mfifo.push_back(zb);
            if (zb.last) begin lock = -1; rr = 0; end
            else lock = 0;
            void'(q0.pop_front());
        end
        if (v1 && r1) begin
            zb.src = 1; zb.last = q1[0].last; zb.data = q1[0].data;
            mfifo.push_back(zb);
            if (zb.last) begin lock = -1; rr = 1; end
            else lock = 1;
            void'(q1.pop_front());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; A0_valid = 1; A1_valid = 1; Z_ready = 1;
        #1;
        chk("rst_z_valid", Z_valid, 0);
        chk("rst_z_data", Z_data, 0);
        chk("rst_z_last", Z_last, 0);
        chk("rst_z_src", Z_src, 0);
        chk("rst_a0_ready", A0_ready, 0);
        chk("rst_a1_ready", A1_ready, 0);
        @(negedge clk);
        rst = 0; A0_valid = 0; A1_valid = 0;
        lock = -1; rr = 1;
        mfifo.delete();
    endtask

    initial begin
        int a, n;
        beat_t b;
        rst = 1; A0_valid = 0; A1_valid = 0; A0_last = 0; A1_last = 0;
        A0_data = '0; A1_data = '0; Z_ready = 0;
        en0 = 0; en1 = 0; lock = -1; rr = 1;
        dut_acc0 = 0; dut_acc1 = 0;
        do_reset();

        // Tie-breaking of single-beat packets from reset.
        for (int i = 0; i < 4; i++) begin
            add_pkt(0, 1); add_pkt(1, 1);
        end
        en0 = 1; en1 = 1; zlog.delete();
        repeat (9) step(1);
        chk("rr_count", zlog.size(), 8);
        if (zlog.size() >= 4)
            for (int i = 0; i < 4; i++) chk("rr_seq", zlog[i].src, i % 2);

        // A1 waits for the whole A0 packet.
        zlog.delete(); en1 = 0;
        add_pkt(0, 4);
        step(1);
        add_pkt(1, 1); en1 = 1;
        repeat (8) step(1);
        chk("lock_count", zlog.size(), 5);
        if (zlog.size() >= 5)
            for (int i = 0; i < 5; i++) chk("lock_seq", zlog[i].src, i == 4);

        // Sink stall fills buffer.
        zlog.delete(); en1 = 0;
        add_pkt(0, 6);
        saved = q0;
        a = dut_acc0;
        repeat (5) step(0);
        chk("stall_acc", dut_acc0 - a, 2);
        repeat (10) step(1);
        chk("stall_count", zlog.size(), 6);
        if (zlog.size() >= 6)
            for (int i = 0; i < 6; i++) chk("stall_data", zlog[i].data, saved[i].data);

        // Toggling sink with both backlogged.
        for (int i = 0; i < 3; i++) begin
            add_pkt(0, 1 + $urandom_range(0, 3));
            add_pkt(1, 1 + $urandom_range(0, 3));
        end
        en0 = 1; en1 = 1;
        for (int i = 0; i < 40; i++) step(i % 2 == 0);
        repeat (10) step(1);

        // Reset mid A1 packet.
        q0.delete(); q1.delete();
        en0 = 0; en1 = 1;
        add_pkt(1, 3);
        a = dut_acc1; n = 0;
        while (dut_acc1 - a < 2 && n < 10) begin
            step(1); n++;
        end
        chk("mid_rst_wait", dut_acc1 - a, 2);
        do_reset();
        q1.delete(); zlog.delete();
        add_pkt(0, 1); add_pkt(1, 1);
        en0 = 1; en1 = 1;
        repeat (4) step(1);
        chk("post_rst_count", zlog.size(), 2);
        if (zlog.size() >= 1) chk("post_rst_src", zlog[0].src, 0);

        // Only A1, known data, single-cycle latency.
        do_reset();
        zlog.delete(); en0 = 0; en1 = 1;
        for (int i = 1; i <= 3; i++) begin
            b.data = BW'(i); b.last = (i == 3);
            q1.push_back(b);
        end
        repeat (6) step(1);
        chk("a1_count", zlog.size(), 3);
        if (zlog.size() >= 3)
            for (int i = 0; i < 3; i++) begin
                chk("a1_data", zlog[i].data, i + 1);
                chk("a1_last", zlog[i].last, i == 2);
            end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if (q0.size() < 2) add_pkt(0, $urandom_range(1, 4));
            if (q1.size() < 2) add_pkt(1, $urandom_range(1, 4));
            en0 = ($urandom % 4) != 0;
            en1 = ($urandom % 4) != 0;
            step(($urandom % 3) != 0);
        end
        en0 = 0; en1 = 0;
        repeat (6) step(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
